slv_mem: RTL and testbench
==========================

# slv_mem

Slave memory that sits directly downstream of the bus master on the simple master/slave bus and serves its write and read requests. Storage is a register array of 2**ADDR_BIT_WIDTH words with a fixed-latency, fully pipelined read path. Illegal simultaneous read/write requests are flagged, and an optional pair of access counters is available for debug.

## Interface
- ADDR_BIT_WIDTH, 2, address bit width; memory depth is 2**ADDR_BIT_WIDTH words
- DATA_BIT_WIDTH, 8, data bit width
- RD_LATENCY, 2, read latency in cycles, legal range 1..8
- CNT_BIT_WIDTH, 16, access counter width (used only with SLV_MEM_ACC_CNT_EN)

One clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_addr  in  ADDR_BIT_WIDTH  R/W address
- i_rd_req  in  1  read request, one word per cycle while high
- i_wr_req  in  1  write request, one word per cycle while high
- i_wr_data  in  DATA_BIT_WIDTH  write data
- o_rd_data  out  DATA_BIT_WIDTH  read data
- o_rd_vld  out  1  o_rd_data valid strobe
- o_req_err  out  1  one-cycle pulse flagging simultaneous rd/wr request
- o_wr_cnt  out  CNT_BIT_WIDTH  accepted write count (macro-gated)
- o_rd_cnt  out  CNT_BIT_WIDTH  accepted read count (macro-gated)

## Operation
- Reset (i_rst_n low) acts immediately, without waiting for a clock edge.
  - All memory words go to 0.
  - The read pipeline is flushed.
  - o_rd_data = 0, o_rd_vld = 0, o_req_err = 0, counters = 0.
- Write: at a rising edge with i_wr_req=1 and i_rd_req=0, mem[i_addr] <= i_wr_data.
- Read: at a rising edge with i_rd_req=1 and i_wr_req=0, mem[i_addr] is sampled into pipeline stage 1.
  - The sample uses memory contents as of before that edge.
- Collision: if i_rd_req=1 and i_wr_req=1 on the same edge:
  - neither the write nor the read is performed;
  - o_req_err = 1 for exactly one cycle;
  - no o_rd_vld is produced.
- The read pipeline is RD_LATENCY stages, each holding a data word and a valid bit. It has no stall and no backpressure; a consumer must accept every o_rd_vld beat.
- o_rd_data holds the last valid value while o_rd_vld=0.
- Addresses are always in range because depth is exactly 2**ADDR_BIT_WIDTH, so no out-of-range handling is needed.
- No internal state machine beyond the pipeline valid shift register and the counters.

## Timing
- Read issued at edge n: o_rd_vld=1 and data valid in the cycle after edge n+RD_LATENCY-1 (i.e. RD_LATENCY cycles after the request cycle).
- Back-to-back reads give one result per cycle, with o_rd_vld continuously high.
- Read-after-write:
  - a read at edge n+1 of an address written at edge n returns the new data;
  - a write and a read at the same edge is a collision (see Operation).
- o_req_err is registered and asserts in the cycle after the offending edge.
- Reset asserted mid-pipeline drops in-flight reads with no late o_rd_vld. After i_rst_n rises, the first request is accepted at the first rising edge.

## Configuration
- SLV_MEM_ACC_CNT_EN defined:
  - o_wr_cnt increments on each accepted write;
  - o_rd_cnt increments on each accepted read;
  - colliding requests are not counted;
  - both counters saturate at 2**CNT_BIT_WIDTH-1 and clear only on reset.
- SLV_MEM_ACC_CNT_EN undefined:
  - no counter logic is built;
  - o_wr_cnt and o_rd_cnt are tied to 0.

## Test plan
All scenarios use ADDR_BIT_WIDTH=2, DATA_BIT_WIDTH=8, RD_LATENCY=2.
- Post-reset read: read addr 0..3 back-to-back -> o_rd_data=0x00 on 4 consecutive o_rd_vld cycles, first one 2 cycles after the first request.
- Write/read sweep: write 0x00,0x01,0x02,0x03 to addr 0..3, then read addr 0..3 -> 0x00..0x03 in order, o_rd_vld high 4 consecutive cycles.
- Read-after-write: write addr 1=0xA5 at edge n, read addr 1 at edge n+1 -> o_rd_data=0xA5 with o_rd_vld=1 two cycles later.
- Collision: rd+wr at addr 2 with data 0x55 (mem[2]=0x02) -> o_req_err=1 for one cycle, no o_rd_vld, subsequent read of addr 2 returns 0x02.
- Reset mid-read: issue a read, drop i_rst_n one cycle later -> o_rd_vld stays 0, then a read of any address returns 0x00.
- Counters (macro on, CNT_BIT_WIDTH=2): 4 writes + 1 collision + 2 reads -> o_wr_cnt=3 (saturated), o_rd_cnt=2; macro off -> both read 0.

Source files
------------

// File: rtl/slv_mem_if.sv
// slv_mem_if: request/response bundle between the bus master and the slv_mem slave.
// The master drives the request fields and receives read data, the error flag and the debug counters.
interface slv_mem_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int CNT_BIT_WIDTH  = 16
);

  logic [ADDR_BIT_WIDTH-1:0] i_addr;
  logic                      i_rd_req;
  logic                      i_wr_req;
  logic [DATA_BIT_WIDTH-1:0] i_wr_data;
  logic [DATA_BIT_WIDTH-1:0] o_rd_data;
  logic                      o_rd_vld;
  logic                      o_req_err;
  logic [CNT_BIT_WIDTH-1:0]  o_wr_cnt;
  logic [CNT_BIT_WIDTH-1:0]  o_rd_cnt;

  modport master (
    output i_addr, i_rd_req, i_wr_req, i_wr_data,
    input  o_rd_data, o_rd_vld, o_req_err, o_wr_cnt, o_rd_cnt
  );

  modport slave (
    input  i_addr, i_rd_req, i_wr_req, i_wr_data,
    output o_rd_data, o_rd_vld, o_req_err, o_wr_cnt, o_rd_cnt
  );

endinterface

// File: rtl/slv_mem.sv
// slv_mem: register-array slave memory with a fixed-latency, fully pipelined read path.
// Define SLV_MEM_ACC_CNT_EN to build the saturating write/read access counters.
module slv_mem #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int RD_LATENCY     = 2,
  parameter int CNT_BIT_WIDTH  = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  slv_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BIT_WIDTH;

  logic [DATA_BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_BIT_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]     pipe_vld_q;
  logic                      req_err_q;

  logic rd_acc;
  logic wr_acc;
  logic req_col;

  // A simultaneous read and write is rejected as a whole: neither side is performed.
  assign rd_acc  = bus.i_rd_req & ~bus.i_wr_req;
  assign wr_acc  = bus.i_wr_req & ~bus.i_rd_req;
  assign req_col = bus.i_rd_req &  bus.i_wr_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[bus.i_addr] <= bus.i_wr_data;
    end
  end

  // Stage data only moves with a valid beat, so the last stage holds the previous result while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data_q[0] <= mem_q[bus.i_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_err_q <= 1'b0;
    end else begin
      req_err_q <= req_col;
    end
  end

  assign bus.o_rd_data = pipe_data_q[RD_LATENCY-1];
  assign bus.o_rd_vld  = pipe_vld_q[RD_LATENCY-1];
  assign bus.o_req_err = req_err_q;

`ifdef SLV_MEM_ACC_CNT_EN
  localparam logic [CNT_BIT_WIDTH-1:0] CNT_ONE = CNT_BIT_WIDTH'(1);

  logic [CNT_BIT_WIDTH-1:0] wr_cnt_q;
  logic [CNT_BIT_WIDTH-1:0] wr_cnt_d;
  logic [CNT_BIT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_BIT_WIDTH-1:0] rd_cnt_d;

  // Counters stick at all-ones; only reset brings them back to zero.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_acc && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
    end
    if (rd_acc && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.o_wr_cnt = wr_cnt_q;
  assign bus.o_rd_cnt = rd_cnt_q;
`else
  assign bus.o_wr_cnt = '0;
  assign bus.o_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_slv_mem.sv
// tb_slv_mem: directed scenarios for slv_mem, checked every cycle against a transaction-level model.
// Counter expectations follow SLV_MEM_ACC_CNT_EN, using a 2-bit counter so saturation is reachable.
module tb_slv_mem;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int CW  = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  slv_mem_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .CNT_BIT_WIDTH(CW)) bus ();

  slv_mem #(
    .ADDR_BIT_WIDTH(AW),
    .DATA_BIT_WIDTH(DW),
    .RD_LATENCY(LAT),
    .CNT_BIT_WIDTH(CW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] memModel [1 << AW];
  beat_t         expQ[$];
  int            edgeCnt = 0;
  logic          errExp;
  logic [DW-1:0] lastData;
  int            wrCntModel;
  int            rdCntModel;

  int            seenCyc[$];
  logic [DW-1:0] seenData[$];
  int            errSeen;

  int tests = 0;
  int fails = 0;

  function automatic void resetModel();
    for (int i = 0; i < (1 << AW); i++) memModel[i] = '0;
    expQ.delete();
    errExp     = 1'b0;
    lastData   = '0;
    wrCntModel = 0;
    rdCntModel = 0;
  endfunction

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endfunction

  function automatic int expCnt(int n);
`ifdef SLV_MEM_ACC_CNT_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return (n < 0) ? n : 0;
`endif
  endfunction

  // A read accepted at edge k must show up after edge k+LAT-1, reading memory as it was before edge k.
  always @(posedge clk) begin
    edgeCnt++;
    if (rst_n) begin
      errExp = bus.i_rd_req && bus.i_wr_req;
      if (bus.i_rd_req && !bus.i_wr_req) begin
        expQ.push_back('{edgeCnt + LAT - 1, memModel[bus.i_addr]});
        rdCntModel++;
      end
      if (bus.i_wr_req && !bus.i_rd_req) begin
        memModel[bus.i_addr] = bus.i_wr_data;
        wrCntModel++;
      end
    end
  end

  always @(negedge rst_n) resetModel();

  always @(negedge clk) begin
    logic expVld;
    expVld = (expQ.size() > 0) && (expQ[0].due == edgeCnt);
    if (expVld) begin
      lastData = expQ[0].data;
      void'(expQ.pop_front());
    end
    checkOutput("rd_vld",  32'(bus.o_rd_vld),  32'(expVld));
    checkOutput("rd_data", 32'(bus.o_rd_data), 32'(lastData));
    checkOutput("req_err", 32'(bus.o_req_err), 32'(errExp));
    checkOutput("wr_cnt",  32'(bus.o_wr_cnt),  32'(expCnt(wrCntModel)));
    checkOutput("rd_cnt",  32'(bus.o_rd_cnt),  32'(expCnt(rdCntModel)));
    if (bus.o_rd_vld) begin
      seenCyc.push_back(edgeCnt);
      seenData.push_back(bus.o_rd_data);
    end
    if (bus.o_req_err) errSeen++;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    bus.i_rd_req  = rd;
    bus.i_wr_req  = wr;
    bus.i_addr    = addr;
    bus.i_wr_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic clearSeen();
    seenCyc.delete();
    seenData.delete();
    errSeen = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstEdge;
    resetModel();
    rst_n = 1'b0;
    bus.i_rd_req = 1'b0; bus.i_wr_req = 1'b0; bus.i_addr = '0; bus.i_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_data", 32'(bus.o_rd_data), 32'h0);
    rst_n = 1'b1;

    // Post-reset read of every address back-to-back
    clearSeen();
    firstEdge = edgeCnt + 1;
    for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, AW'(a), '0);
    idle(4);
    checkOutput("post_reset_beats", 32'(seenData.size()), 32'd4);
    if (seenData.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("post_reset_data", 32'(seenData[i]), 32'h00);
      checkOutput("post_reset_first_edge", 32'(seenCyc[0]), 32'(firstEdge + 1));
      checkOutput("post_reset_last_edge",  32'(seenCyc[3]), 32'(firstEdge + 4));
    end

    // Write/read sweep
    for (int a = 0; a < 4; a++) applyStimulus(1'b0, 1'b1, AW'(a), DW'(a));
    clearSeen();
    for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, AW'(a), '0);
    idle(4);
    checkOutput("sweep_beats", 32'(seenData.size()), 32'd4);
    if (seenData.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("sweep_data", 32'(seenData[i]), 32'(i));
      checkOutput("sweep_span", 32'(seenCyc[3] - seenCyc[0]), 32'd3);
    end

    // Read-after-write on the next edge
    applyStimulus(1'b0, 1'b1, 2'd1, 8'hA5);
    clearSeen();
    firstEdge = edgeCnt + 1;
    applyStimulus(1'b1, 1'b0, 2'd1, '0);
    idle(3);
    checkOutput("raw_beats", 32'(seenData.size()), 32'd1);
    if (seenData.size() == 1) begin
      checkOutput("raw_data", 32'(seenData[0]), 32'hA5);
      checkOutput("raw_edge", 32'(seenCyc[0]), 32'(firstEdge + 1));
    end

    // Collision leaves memory untouched and yields one error pulse
    clearSeen();
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h55);
    idle(3);
    checkOutput("col_beats", 32'(seenData.size()), 32'd0);
    checkOutput("col_err_pulses", 32'(errSeen), 32'd1);
    clearSeen();
    applyStimulus(1'b1, 1'b0, 2'd2, '0);
    idle(3);
    checkOutput("col_readback_beats", 32'(seenData.size()), 32'd1);
    if (seenData.size() == 1) checkOutput("col_readback_data", 32'(seenData[0]), 32'h02);

    // Reset in the middle of a read
    clearSeen();
    applyStimulus(1'b1, 1'b0, 2'd3, '0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    checkOutput("midrst_beats", 32'(seenData.size()), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'd3, '0);
    idle(3);
    checkOutput("midrst_readback_beats", 32'(seenData.size()), 32'd1);
    if (seenData.size() == 1) checkOutput("midrst_readback_data", 32'(seenData[0]), 32'h00);

    // Counters: 4 writes, 1 collision, 2 reads from a clean reset
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) applyStimulus(1'b0, 1'b1, AW'(a), DW'(8'h10 + a));
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hFF);
    applyStimulus(1'b1, 1'b0, 2'd0, '0);
    applyStimulus(1'b1, 1'b0, 2'd1, '0);
    idle(3);
`ifdef SLV_MEM_ACC_CNT_EN
    checkOutput("cnt_wr_final", 32'(bus.o_wr_cnt), 32'd3);
    checkOutput("cnt_rd_final", 32'(bus.o_rd_cnt), 32'd2);
`else
    checkOutput("cnt_wr_final", 32'(bus.o_wr_cnt), 32'd0);
    checkOutput("cnt_rd_final", 32'(bus.o_rd_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
